// File: rtl/ex_operand_if.sv
// ID/EX operand stage bus: decode inputs, forwarding taps and
// registered EX-side outputs.
interface ex_operand_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [15:0]   imm16;
  logic [RW-1:0] rs_addr;
  logic [RW-1:0] rt_addr;
  logic [RW-1:0] rd_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          ex_valid;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [2:0]    aluop;
  logic [RW-1:0] ex_dest;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_branch;
  logic [DW-1:0] ex_store_data;
  logic          illegal;

  modport master (
    output stall, flush, id_valid,
    output opcode, funct, shamt, imm16,
    output rs_addr, rt_addr, rd_addr,
    output rs_data, rt_data,
    output exmem_regwrite, exmem_rd,
    output exmem_result,
    output memwb_regwrite, memwb_rd,
    output memwb_result,
    input  ex_valid, alu_in1, alu_in2,
    input  aluop, ex_dest, ex_regwrite,
    input  ex_memread, ex_memwrite,
    input  ex_branch, ex_store_data,
    input  illegal
  );

  modport slave (
    input  stall, flush, id_valid,
    input  opcode, funct, shamt, imm16,
    input  rs_addr, rt_addr, rd_addr,
    input  rs_data, rt_data,
    input  exmem_regwrite, exmem_rd,
    input  exmem_result,
    input  memwb_regwrite, memwb_rd,
    input  memwb_result,
    output ex_valid, alu_in1, alu_in2,
    output aluop, ex_dest, ex_regwrite,
    output ex_memread, ex_memwrite,
    output ex_branch, ex_store_data,
    output illegal
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX stage: decodes aluop, forwards rs/rt and registers
// operands and controls for the ALU.
module ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  ex_operand_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [2:0]    op;
    logic [RW-1:0] dest;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          br;
    logic [DW-1:0] sd;
  } ex_t;

  ex_t           dec;
  ex_t           ex_d;
  ex_t           ex_q;
  logic          dec_ok;
  logic          rw_raw;
  logic          ill_d;
  logic          ill_q;
  logic [DW-1:0] fs;
  logic [DW-1:0] ft;
  logic [DW-1:0] sx;
  logic [DW-1:0] zx;
  logic [DW-1:0] shz;

  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] addr,
    input logic [DW-1:0] rf
  );
    if (bus.exmem_regwrite &&
        bus.exmem_rd != '0 &&
        bus.exmem_rd == addr)
      return bus.exmem_result;
    if (bus.memwb_regwrite &&
        bus.memwb_rd != '0 &&
        bus.memwb_rd == addr)
      return bus.memwb_result;
    return rf;
  endfunction

  assign fs  = fwd(bus.rs_addr, bus.rs_data);
  assign ft  = fwd(bus.rt_addr, bus.rt_data);
  assign sx  = {{(DW-16){bus.imm16[15]}}, bus.imm16};
  assign zx  = {{(DW-16){1'b0}}, bus.imm16};
  assign shz = {{(DW-5){1'b0}}, bus.shamt};

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.in1   = fs;
    dec.in2   = ft;
    dec.sd    = ft;
    dec_ok    = 1'b1;
    rw_raw    = 1'b0;
    unique case (bus.opcode)
      6'h00: begin
        dec.dest = bus.rd_addr;
        rw_raw   = 1'b1;
        unique case (bus.funct)
          6'h20: dec.op = 3'd0;
          6'h22: dec.op = 3'd1;
          6'h24: dec.op = 3'd2;
          6'h25: dec.op = 3'd3;
          6'h2A: dec.op = 3'd6;
          6'h00: begin
            dec.op  = 3'd4;
            dec.in1 = ft;
            dec.in2 = shz;
          end
          6'h02: begin
            dec.op  = 3'd5;
            dec.in1 = ft;
            dec.in2 = shz;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h08: begin
        dec.in2  = sx;
        dec.dest = bus.rt_addr;
        rw_raw   = 1'b1;
      end
      6'h0A: begin
        dec.op   = 3'd6;
        dec.in2  = sx;
        dec.dest = bus.rt_addr;
        rw_raw   = 1'b1;
      end
      6'h0C: begin
        dec.op   = 3'd2;
        dec.in2  = zx;
        dec.dest = bus.rt_addr;
        rw_raw   = 1'b1;
      end
      6'h0D: begin
        dec.op   = 3'd3;
        dec.in2  = zx;
        dec.dest = bus.rt_addr;
        rw_raw   = 1'b1;
      end
      6'h23: begin
        dec.in2  = sx;
        dec.dest = bus.rt_addr;
        dec.mr   = 1'b1;
        rw_raw   = 1'b1;
      end
      6'h2B: begin
        dec.in2 = sx;
        dec.mw  = 1'b1;
      end
      6'h04: begin
        dec.op = 3'd1;
        dec.br = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    // writes to $0 are dropped here so downstream never sees them
    dec.rw = rw_raw && (dec.dest != '0);
    ex_d   = (bus.id_valid && dec_ok) ? dec : '0;
    ill_d  = bus.id_valid && !dec_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      ill_q <= 1'b0;
    end else if (bus.flush) begin
      ex_q  <= '0;
      ill_q <= 1'b0;
    end else if (bus.stall) begin
      ill_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      ill_q <= ill_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.alu_in1       = ex_q.in1;
  assign bus.alu_in2       = ex_q.in2;
  assign bus.aluop         = ex_q.op;
  assign bus.ex_dest       = ex_q.dest;
  assign bus.ex_regwrite   = ex_q.rw;
  assign bus.ex_memread    = ex_q.mr;
  assign bus.ex_memwrite   = ex_q.mw;
  assign bus.ex_branch     = ex_q.br;
  assign bus.ex_store_data = ex_q.sd;
  assign bus.illegal       = ill_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scoreboard bench for ex_operand_stage.
module tb_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic        valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  ex_operand_if #(.DW(32), .RW(5)) bus ();

  ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic        v,
    input logic [31:0] i1,
    input logic [31:0] i2,
    input logic [2:0]  op,
    input logic [4:0]  dst,
    input logic        rw,
    input logic        mr,
    input logic        mw,
    input logic        br,
    input logic [31:0] sd,
    input logic        ill
  );
    exp_t e;
    e = '{v, i1, i2, op, dst, rw,
          mr, mw, br, sd, ill};
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{bus.ex_valid, bus.alu_in1,
          bus.alu_in2, bus.aluop,
          bus.ex_dest, bus.ex_regwrite,
          bus.ex_memread, bus.ex_memwrite,
          bus.ex_branch, bus.ex_store_data,
          bus.illegal};
    return o;
  endfunction

  task automatic chk_pop(input string tag);
    exp_t e;
    exp_t o;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      o = observed();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s obs=%h exp=%h",
               tag, o, e);
      end
    end
  endtask

  task automatic now(input string tag,
                     input exp_t e);
    sb.push_back(e);
    chk_pop(tag);
  endtask

  task automatic step(input string tag,
                      input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk_pop(tag);
  endtask

  task automatic instr(
    input logic [5:0]  op,
    input logic [5:0]  fn,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [31:0] rsd,
    input logic [31:0] rtd
  );
    bus.id_valid = 1'b1;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.shamt    = sh;
    bus.imm16    = imm;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
    bus.rd_addr  = rd;
    bus.rs_data  = rsd;
    bus.rt_data  = rtd;
  endtask

  task automatic fwd(
    input logic        ew,
    input logic [4:0]  erd,
    input logic [31:0] er,
    input logic        mw,
    input logic [4:0]  mrd,
    input logic [31:0] mres
  );
    bus.exmem_regwrite = ew;
    bus.exmem_rd       = erd;
    bus.exmem_result   = er;
    bus.memwb_regwrite = mw;
    bus.memwb_rd       = mrd;
    bus.memwb_result   = mres;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t z;
    exp_t swe;
    exp_t adde;
    total = 0;
    bad   = 0;
    z     = '0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    instr(6'h00, 6'h20, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd10, 32'd5);
    bus.id_valid = 1'b0;
    fwd(0, 0, 0, 0, 0, 0);
    #12;
    now("reset", z);
    rst_n = 1'b1;

    instr(6'h00, 6'h20, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd10, 32'd5);
    adde = mk(1, 10, 5, 0, 3, 1, 0, 0, 0, 5, 0);
    step("add", adde);

    fwd(1, 5'd1, 32'd7, 1, 5'd1, 32'd9);
    step("fwd_exmem",
         mk(1, 7, 5, 0, 3, 1, 0, 0, 0, 5, 0));
    fwd(0, 5'd1, 32'd7, 1, 5'd1, 32'd9);
    step("fwd_memwb",
         mk(1, 9, 5, 0, 3, 1, 0, 0, 0, 5, 0));
    fwd(1, 5'd0, 32'd7, 1, 5'd0, 32'd9);
    step("fwd_rd0",
         mk(1, 10, 5, 0, 3, 1, 0, 0, 0, 5, 0));
    fwd(1, 5'd2, 32'd77, 0, 5'd0, 32'd0);
    step("fwd_rt",
         mk(1, 10, 77, 0, 3, 1, 0, 0, 0, 77, 0));
    fwd(0, 0, 0, 0, 0, 0);

    instr(6'h08, 6'h00, 5'd0, 16'hFFFB,
          5'd1, 5'd4, 5'd0, 32'd10, 32'd5);
    step("addi_sx",
         mk(1, 10, 32'hFFFFFFFB, 0, 4, 1,
            0, 0, 0, 5, 0));
    instr(6'h0D, 6'h00, 5'd0, 16'hFFFB,
          5'd1, 5'd4, 5'd0, 32'd10, 32'd5);
    step("ori_zx",
         mk(1, 10, 32'h0000FFFB, 3, 4, 1,
            0, 0, 0, 5, 0));
    instr(6'h00, 6'h02, 5'd3, 16'h0,
          5'd1, 5'd2, 5'd6, 32'd10, 32'h80);
    step("srl",
         mk(1, 32'h80, 3, 5, 6, 1,
            0, 0, 0, 32'h80, 0));
    instr(6'h00, 6'h2A, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd7, 32'd3, 32'd9);
    step("slt",
         mk(1, 3, 9, 6, 7, 1, 0, 0, 0, 9, 0));
    instr(6'h23, 6'h00, 5'd0, 16'h0010,
          5'd1, 5'd8, 5'd0, 32'd200, 32'd1);
    step("lw",
         mk(1, 200, 16, 0, 8, 1, 1, 0, 0, 1, 0));
    instr(6'h04, 6'h00, 5'd0, 16'h0004,
          5'd1, 5'd2, 5'd0, 32'd6, 32'd6);
    step("beq",
         mk(1, 6, 6, 1, 0, 0, 0, 0, 1, 6, 0));

    instr(6'h2B, 6'h00, 5'd0, 16'h0008,
          5'd1, 5'd2, 5'd0, 32'd100, 32'd55);
    swe = mk(1, 100, 8, 0, 0, 0, 0, 1, 0, 55, 0);
    step("sw", swe);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(6'h00, 6'h22, 5'd0, 16'h0,
            5'd3, 5'd4, 5'd9,
            $urandom, $urandom);
      step("stall_hold", swe);
    end
    bus.flush = 1'b1;
    step("flush_stall", z);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    instr(6'h3F, 6'h00, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
    step("illegal_op",
         mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    bus.id_valid = 1'b0;
    step("illegal_clear", z);
    instr(6'h00, 6'h3F, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
    step("illegal_fn",
         mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    instr(6'h00, 6'h20, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd10, 32'd5);
    step("add2", adde);
    bus.stall = 1'b1;
    instr(6'h3F, 6'h00, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
    step("illegal_stall", adde);
    bus.stall = 1'b0;

    instr(6'h08, 6'h00, 5'd0, 16'h0003,
          5'd1, 5'd0, 5'd0, 32'd10, 32'd0);
    step("addi_r0",
         mk(1, 10, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    instr(6'h00, 6'h00, 5'd0, 16'h0,
          5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step("nop",
         mk(1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));

    instr(6'h00, 6'h20, 5'd0, 16'h0,
          5'd1, 5'd2, 5'd3, 32'd10, 32'd5);
    step("add3", adde);
    bus.stall = 1'b1;
    rst_n = 1'b0;
    #1;
    now("async_reset", z);
    #2;
    rst_n = 1'b1;
    step("reset_stall", z);
    bus.stall = 1'b0;
    step("post_reset", adde);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
